// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad matrix constants and emulator state encoding
package keypad_pkg;

   localparam logic [3:0] ROW0     = 4'b1110;
   localparam logic [3:0] ROW1     = 4'b1101;
   localparam logic [3:0] ROW2     = 4'b1011;
   localparam logic [3:0] ROW3     = 4'b0111;
   localparam logic [3:0] ROW_NONE = 4'b1111;

   localparam logic [2:0] COL0     = 3'b110;
   localparam logic [2:0] COL1     = 3'b101;
   localparam logic [2:0] COL2     = 3'b011;
   localparam logic [2:0] COL_NONE = 3'b111;

   localparam logic [3:0] KEY_INVALID_MIN = 4'd12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESS   = 2'd1,
      RELEASE = 2'd2
   } kp_state_t;

   function automatic int clamp_min1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/keypad_keymap.sv
// rtl/keypad_keymap.sv - keycode to one-cold row / active-low column pattern
module keypad_keymap
   import keypad_pkg::*;
(
   input  logic [3:0] i_key,
   output logic [3:0] o_row,
   output logic [2:0] o_col,
   output logic       o_valid
);

   always_comb begin
      o_row = ROW_NONE;
      o_col = COL_NONE;
      case (i_key)
         4'd1:    begin o_row = ROW0; o_col = COL0; end
         4'd2:    begin o_row = ROW0; o_col = COL1; end
         4'd3:    begin o_row = ROW0; o_col = COL2; end
         4'd4:    begin o_row = ROW1; o_col = COL0; end
         4'd5:    begin o_row = ROW1; o_col = COL1; end
         4'd6:    begin o_row = ROW1; o_col = COL2; end
         4'd7:    begin o_row = ROW2; o_col = COL0; end
         4'd8:    begin o_row = ROW2; o_col = COL1; end
         4'd9:    begin o_row = ROW2; o_col = COL2; end
         4'd10:   begin o_row = ROW3; o_col = COL0; end
         4'd0:    begin o_row = ROW3; o_col = COL1; end
         4'd11:   begin o_row = ROW3; o_col = COL2; end
         default: begin o_row = ROW_NONE; o_col = COL_NONE; end
      endcase
   end

   assign o_valid = (i_key < KEY_INVALID_MIN);

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - types keycodes onto a 4x3 matrix scan as timed press/release
// Optional key chatter at the start of each press: KEYPAD_EMU_BOUNCE_EN
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_SCANS   = 4,
   parameter int GAP_SCANS    = 4,
   parameter int BOUNCE_SCANS = 2,
   parameter int CNT_W        = 8
)(
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] in_key,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] rows,
   output logic [2:0] cols,
   output logic       pressed,
   output logic       err_key
);

   localparam int HOLD_EFF = clamp_min1(HOLD_SCANS);
   localparam int GAP_EFF  = clamp_min1(GAP_SCANS);
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam bit BOUNCE_ON = 1'b1;
`else
   localparam bit BOUNCE_ON = 1'b0;
`endif
   localparam int BOUNCE_LIM = !BOUNCE_ON        ? 0 :
                               (BOUNCE_SCANS < 0) ? 0 :
                               (BOUNCE_SCANS < HOLD_EFF) ? BOUNCE_SCANS : HOLD_EFF;

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_EFF - 1);
   localparam logic [CNT_W-1:0] BOUNCE_END = CNT_W'(BOUNCE_LIM);

   kp_state_t        r_state;
   logic [3:0]       r_rows_q;
   logic [3:0]       r_row;
   logic [2:0]       r_col;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in_ready;
   logic             r_pressed;
   logic             r_err_key;

   logic [3:0]       w_map_row;
   logic [2:0]       w_map_col;
   logic             w_map_valid;
   logic             w_tick;
   logic             w_handshake;
   logic             w_bounce_off;

   keypad_keymap u_keymap (
      .i_key   (in_key),
      .o_row   (w_map_row),
      .o_col   (w_map_col),
      .o_valid (w_map_valid)
   );

   // One tick per full scan: the cycle the scanner returns to the first row.
   assign w_tick       = (rows == ROW0) && (r_rows_q != ROW0);
   assign w_handshake  = in_valid && r_in_ready;
   assign w_bounce_off = (r_cnt < BOUNCE_END) && r_cnt[0];

   // Zero-latency response: the scanner samples rows and cols on the same edge.
   assign cols = ((r_state == PRESS) && (rows == r_row) && !w_bounce_off) ? r_col : COL_NONE;

   assign in_ready = r_in_ready;
   assign pressed  = r_pressed;
   assign err_key  = r_err_key;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rows_q   <= ROW_NONE;
         r_row      <= ROW_NONE;
         r_col      <= COL_NONE;
         r_cnt      <= '0;
         r_in_ready <= 1'b1;
         r_pressed  <= 1'b0;
         r_err_key  <= 1'b0;
      end else begin
         r_rows_q  <= rows;
         r_err_key <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_handshake) begin
                  if (w_map_valid) begin
                     r_row      <= w_map_row;
                     r_col      <= w_map_col;
                     r_cnt      <= '0;
                     r_state    <= PRESS;
                     r_in_ready <= 1'b0;
                     r_pressed  <= 1'b1;
                  end else begin
                     r_err_key  <= 1'b1;
                  end
               end
            end
            PRESS: begin
               if (w_tick) begin
                  if (r_cnt == HOLD_LAST) begin
                     r_cnt     <= '0;
                     r_state   <= RELEASE;
                     r_pressed <= 1'b0;
                  end else begin
                     r_cnt     <= r_cnt + CNT_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (w_tick) begin
                  if (r_cnt == GAP_LAST) begin
                     r_cnt      <= '0;
                     r_state    <= IDLE;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_cnt      <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
               r_pressed  <= 1'b0;
            end
         endcase
      end
   end

endmodule
